// File: rtl/gray_rx_tracker_if.sv
// rtl/gray_rx_tracker_if.sv - Gray source / position consumer signal bundle for gray_rx_tracker
interface gray_rx_tracker_if #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] gray_in;
    logic             err_clr;
    logic [WIDTH-1:0] bin_out;
    logic             step;
    logic             dir;
    logic [CNT_W-1:0] pos;
    logic             err;
    logic             err_sticky;

    modport master (
        output gray_in, err_clr,
        input  bin_out, step, dir, pos, err, err_sticky
    );

    modport slave (
        input  gray_in, err_clr,
        output bin_out, step, dir, pos, err, err_sticky
    );
endinterface

// File: rtl/gray_rx_tracker.sv
// rtl/gray_rx_tracker.sv - Gray code receiver: synchroniser, decoder, step/position tracker
module gray_rx_tracker #(
    parameter int WIDTH       = 2,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               res_n,
    gray_rx_tracker_if.slave   bus
);
    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic {
        ST_INIT,
        ST_TRACK
    } state_t;

    logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]  s_last;
    logic [WIDTH-1:0]  b_cur;
    logic [WIDTH-1:0]  delta;
    logic              is_up;
    logic              is_down;
    logic              is_jump;

    state_t            state_q;
    logic [FILL_W-1:0] fill_q;
    logic [WIDTH-1:0]  bin_out_q;
    logic              step_q;
    logic              dir_q;
    logic [CNT_W-1:0]  pos_q;
    logic              err_q;
    logic              err_sticky_q;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s_last = sync_q[SYNC_STAGES-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        b_cur = '0;
        b_cur[WIDTH-1] = s_last[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b_cur[i] = b_cur[i+1] ^ s_last[i];
        end
    end

    assign delta   = b_cur - bin_out_q;
    assign is_up   = (delta == WIDTH'(1));
    assign is_down = (delta == {WIDTH{1'b1}});
    assign is_jump = (delta != '0) && !is_up && !is_down;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q      <= ST_INIT;
            fill_q       <= '0;
            bin_out_q    <= '0;
            step_q       <= 1'b0;
            dir_q        <= 1'b0;
            pos_q        <= '0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            step_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                // Wait until the chain is flushed of reset zeros, then adopt the
                // first real sample as the reference without producing a step.
                ST_INIT: begin
                    if (fill_q == FILL_W'(SYNC_STAGES)) begin
                        bin_out_q <= b_cur;
                        state_q   <= ST_TRACK;
                    end else begin
                        fill_q <= fill_q + FILL_W'(1);
                    end
                end
                ST_TRACK: begin
                    bin_out_q <= b_cur;
                    if (is_up) begin
                        step_q <= 1'b1;
                        dir_q  <= 1'b1;
                        pos_q  <= pos_q + CNT_W'(1);
                    end else if (is_down) begin
                        step_q <= 1'b1;
                        dir_q  <= 1'b0;
                        pos_q  <= pos_q - CNT_W'(1);
                    end else if (is_jump) begin
                        err_q <= 1'b1;
                    end
                    // A new error outranks a simultaneous clear request.
                    if (is_jump) begin
                        err_sticky_q <= 1'b1;
                    end else if (bus.err_clr) begin
                        err_sticky_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign bus.bin_out    = bin_out_q;
    assign bus.step       = step_q;
    assign bus.dir        = dir_q;
    assign bus.pos        = pos_q;
    assign bus.err        = err_q;
    assign bus.err_sticky = err_sticky_q;
endmodule

// File: tb/tb_gray_rx_tracker.sv
// tb/tb_gray_rx_tracker.sv - directed and randomized self-checking bench for gray_rx_tracker
module tb_gray_rx_tracker;
    localparam int WIDTH = 2;
    localparam int CNT_W = 8;
    localparam int S     = 2;
    localparam int NCODE = 1 << WIDTH;
    localparam int NPOS  = 1 << CNT_W;

    logic clk;
    logic res_n;
    int   checks;
    int   errors;

    gray_rx_tracker_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    gray_rx_tracker #(
        .WIDTH       (WIDTH),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (S)
    ) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: history of the code presented at each edge since release.
    int hist[$];
    int m_bin, m_pos, m_dir, m_step, m_err, m_sticky;
    int last_g;

    function automatic int g2b(input int g);
        for (int i = 0; i < NCODE; i++) begin
            if ((i ^ (i >> 1)) == g) return i;
        end
        return -1;
    endfunction

    function automatic int b2g(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".bin_out"},    int'(bus.bin_out),    m_bin);
        chk({tag, ".step"},       int'(bus.step),       m_step);
        chk({tag, ".dir"},        int'(bus.dir),        m_dir);
        chk({tag, ".pos"},        int'(bus.pos),        m_pos);
        chk({tag, ".err"},        int'(bus.err),        m_err);
        chk({tag, ".err_sticky"}, int'(bus.err_sticky), m_sticky);
    endtask

    task automatic model_reset();
        hist.delete();
        m_bin = 0; m_pos = 0; m_dir = 0; m_step = 0; m_err = 0; m_sticky = 0;
    endtask

    task automatic tick(input int g, input logic clr);
        int n, cur, d;
        @(negedge clk);
        bus.gray_in = WIDTH'(g);
        bus.err_clr = clr;
        last_g = g;
        @(posedge clk);
        hist.push_back(g);
        n = hist.size();
        m_step = 0;
        m_err  = 0;
        if (n == S + 1) begin
            m_bin = g2b(hist[0]);
        end else if (n > S + 1) begin
            cur = g2b(hist[n - 1 - S]);
            d = (cur - m_bin + NCODE) % NCODE;
            if (d == 1) begin
                m_step = 1; m_dir = 1; m_pos = (m_pos + 1) % NPOS;
            end else if (d == NCODE - 1) begin
                m_step = 1; m_dir = 0; m_pos = (m_pos + NPOS - 1) % NPOS;
            end else if (d != 0) begin
                m_err = 1;
            end
            m_bin = cur;
            if (m_err != 0) m_sticky = 1;
            else if (clr) m_sticky = 0;
        end
        #1;
        chk_all("tick");
    endtask

    task automatic hold(input int g, input logic clr, input int n);
        for (int i = 0; i < n; i++) tick(g, clr);
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic do_reset(input int g);
        @(negedge clk);
        bus.gray_in = WIDTH'(g);
        bus.err_clr = 1'b0;
        last_g = g;
        #2 res_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1 res_n = 1'b1;
    endtask

    initial begin
        int g, r;
        logic clr;
        checks = 0;
        errors = 0;
        res_n = 1'b0;
        bus.gray_in = '0;
        bus.err_clr = 1'b0;
        last_g = 0;
        model_reset();

        // 1: full up cycle
        do_reset(0);
        hold(0, 1'b0, 4);
        hold(1, 1'b0, 4);
        hold(3, 1'b0, 4);
        hold(2, 1'b0, 4);
        hold(0, 1'b0, 4);
        chk("t1.pos", int'(bus.pos), 4);
        chk("t1.bin", int'(bus.bin_out), 0);
        chk("t1.dir", int'(bus.dir), 1);

        // 2: down step from zero wraps
        do_reset(0);
        hold(0, 1'b0, 4);
        hold(2, 1'b0, 4);
        chk("t2.pos", int'(bus.pos), 255);
        chk("t2.bin", int'(bus.bin_out), 3);
        chk("t2.dir", int'(bus.dir), 0);

        // 3: illegal jump 0->2, then legal step 2->3
        hold(0, 1'b0, 4);
        hold(3, 1'b0, 2);
        tick(3, 1'b0);
        chk("t3.err", int'(bus.err), 1);
        chk("t3.sticky", int'(bus.err_sticky), 1);
        chk("t3.step", int'(bus.step), 0);
        chk("t3.pos", int'(bus.pos), 0);
        chk("t3.bin", int'(bus.bin_out), 2);
        hold(3, 1'b0, 2);
        hold(2, 1'b0, 4);
        chk("t3.pos_after", int'(bus.pos), 1);
        chk("t3.sticky_held", int'(bus.err_sticky), 1);

        // 4: nonzero code held through reset
        do_reset(2);
        hold(2, 1'b0, 5);
        chk("t4.bin", int'(bus.bin_out), 3);
        chk("t4.pos", int'(bus.pos), 0);
        chk("t4.err", int'(bus.err), 0);

        // 5: latency of a single toggle, then err and err_clr together
        tick(3, 1'b0);
        tick(3, 1'b0);
        chk("t5.step_k1", int'(bus.step), 0);
        tick(3, 1'b0);
        chk("t5.step_k2", int'(bus.step), 1);
        tick(3, 1'b0);
        chk("t5.step_k3", int'(bus.step), 0);
        tick(0, 1'b1);
        tick(0, 1'b1);
        tick(0, 1'b1);
        chk("t5.err", int'(bus.err), 1);
        chk("t5.sticky_set_wins", int'(bus.err_sticky), 1);
        tick(0, 1'b1);
        chk("t5.sticky_cleared", int'(bus.err_sticky), 0);

        // 6: async reset at pos 7, INIT re-entered
        do_reset(0);
        hold(0, 1'b0, 4);
        for (int i = 1; i <= 7; i++) hold(b2g(i % NCODE), 1'b0, 3);
        hold(last_g, 1'b0, 2);
        chk("t6.pos", int'(bus.pos), 7);
        do_reset(last_g);
        chk("t6.pos_rst", int'(bus.pos), 0);
        hold(last_g, 1'b0, 2);
        chk("t6.init_bin", int'(bus.bin_out), 0);
        tick(last_g, 1'b0);
        chk("t6.bin_after_init", int'(bus.bin_out), 3);
        chk("t6.step_after_init", int'(bus.step), 0);

        // Randomized walk: mostly legal steps, some holds and arbitrary jumps
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60) begin
                g = b2g((g2b(last_g) + (($urandom_range(0, 1) == 1) ? 1 : NCODE - 1)) % NCODE);
            end else if (r < 80) begin
                g = last_g;
            end else begin
                g = $urandom_range(0, NCODE - 1);
            end
            clr = ($urandom_range(0, 9) == 0);
            hold(g, clr, $urandom_range(1, 3));
            if ($urandom_range(0, 199) == 0) do_reset($urandom_range(0, NCODE - 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
